// File: rtl/convo_pkg.sv
// Shared types and constants for the convolution window scheduler.
package convo_pkg;

    localparam int DIM_W    = 5;   // map dimension / position counter width
    localparam int STRIDE_W = 3;   // stride input width
    localparam int KSIZE    = 3;   // kernel side, fixed
    localparam int STRIDE_1 = 1;
    localparam int STRIDE_2 = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/convo_pos_counter.sv
// Wrapping position counter with a stride-2 phase bit.
// lead: position is past the kernel lead-in (cnt >= 2).
// aligned: (cnt-2) is a multiple of the stride.
// idx: output-map coordinate for this position.
module convo_pos_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         stride2,
    input  logic [W-1:0] last,
    output logic         wrap,
    output logic         lead,
    output logic         aligned,
    output logic [W-1:0] idx
);

    logic [W-1:0] cnt;
    logic         phase;   // parity of (cnt-2); cnt starts even, so phase tracks cnt[0]

    assign wrap    = en && (cnt == last);
    assign lead    = cnt >= W'(2);
    assign aligned = !stride2 || !phase;
    assign idx     = (cnt - W'(2)) >> stride2;

    // Count accepted positions; restart at 0 on wrap or new frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (clr || wrap) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (en) begin
            cnt   <= cnt + W'(1);
            phase <= ~phase;
        end
    end

endmodule

// File: rtl/convo_window_sched.sv
// Sequences one feature map through the line-buffer FIFO and 3x3 window,
// applying the stride and handshaking each legal window with the MAC.
module convo_window_sched
    import convo_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DIM_W-1:0]    row_len,
    input  logic [DIM_W-1:0]    col_len,
    input  logic [STRIDE_W-1:0] stride,
    input  logic                pix_valid,
    output logic                pix_ready,
    output logic                ff_rst,
    output logic                ff_wen,
    output logic                ff_ren,
    output logic                win_valid,
    input  logic                win_ready,
    output logic [DIM_W-1:0]    out_row,
    output logic [DIM_W-1:0]    out_col,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);

    state_t           state, state_nx;
    logic [DIM_W-1:0] row_last, col_last;
    logic             stride2;
    logic             last_seen;   // final pixel of the frame has been accepted
    logic             cfg_bad, start_ok, accept, win_hs, legal_acc;
    logic             col_wrap, row_wrap, c_lead, c_al, r_lead, r_al;
    logic [DIM_W-1:0] c_idx, r_idx;

    assign cfg_bad   = (row_len < DIM_W'(KSIZE)) || (col_len < DIM_W'(KSIZE)) ||
                       !((stride == STRIDE_W'(STRIDE_1)) || (stride == STRIDE_W'(STRIDE_2)));
    assign start_ok  = (state == IDLE) && start && !cfg_bad;
    assign win_hs    = win_valid && win_ready;
    assign pix_ready = (state == RUN) && !last_seen && !(win_valid && !win_ready);
    assign accept    = pix_valid && pix_ready;
    assign ff_wen    = accept;
    assign ff_ren    = accept && r_lead;   // FIFO keeps two rows in flight
    assign ff_rst    = (state == CLEAR);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign legal_acc = accept && c_lead && c_al && r_lead && r_al;

    convo_pos_counter #(.W(DIM_W)) u_col (
        .clk(clk), .rst(rst), .clr(start_ok), .en(accept), .stride2(stride2),
        .last(row_last), .wrap(col_wrap), .lead(c_lead), .aligned(c_al), .idx(c_idx)
    );

    // Row advances only on the column wrap; its wrap marks the last pixel.
    convo_pos_counter #(.W(DIM_W)) u_row (
        .clk(clk), .rst(rst), .clr(start_ok), .en(accept && col_wrap), .stride2(stride2),
        .last(col_last), .wrap(row_wrap), .lead(r_lead), .aligned(r_al), .idx(r_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state: leave RUN only after the last pixel and any pending window drain.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = CLEAR;
            CLEAR:   state_nx = RUN;
            RUN:     if (last_seen && (!win_valid || win_ready)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Config latch, end-of-frame flag and config-error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_last  <= '0;
            col_last  <= '0;
            stride2   <= 1'b0;
            last_seen <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= (state == IDLE) && start && cfg_bad;
            if (start_ok) begin
                row_last  <= row_len - DIM_W'(1);
                col_last  <= col_len - DIM_W'(1);
                stride2   <= (stride == STRIDE_W'(STRIDE_2));
                last_seen <= 1'b0;
            end else if (accept && row_wrap) begin
                last_seen <= 1'b1;
            end
        end
    end

    // Window output register: set on a legal accept, cleared on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
        end else if (legal_acc) begin
            win_valid <= 1'b1;
            out_row   <= r_idx;
            out_col   <= c_idx;
        end else if (win_hs) begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_convo_window_sched.sv
// Randomized scoreboard bench for convo_window_sched.
module tb_convo_window_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [4:0] row_len = '0, col_len = '0;
    logic [2:0] stride = '0;
    logic       pix_valid = 1'b0, win_ready = 1'b0;
    logic       pix_ready, ff_rst, ff_wen, ff_ren, win_valid, busy, done, cfg_err;
    logic [4:0] out_row, out_col;

    convo_window_sched dut (
        .clk(clk), .rst(rst), .start(start), .row_len(row_len), .col_len(col_len),
        .stride(stride), .pix_valid(pix_valid), .pix_ready(pix_ready), .ff_rst(ff_rst),
        .ff_wen(ff_wen), .ff_ren(ff_ren), .win_valid(win_valid), .win_ready(win_ready),
        .out_row(out_row), .out_col(out_col), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {int r; int c;} win_t;
    win_t sb[$];
    win_t w;

    int checks = 0, failures = 0;
    int cur_rl = 5, cur_s = 1, pix_k = 0, cyc = 0, last_hs_cyc = -10;
    int n_wen = 0, n_ren = 0, n_rst = 0, stall_left = 0;
    int tr, tc, pend_r, pend_c, prow, pcol;
    bit vmode_rand = 0, rmode_rand = 0, gap_chk = 0, pend = 0, pv = 0, phs = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Input driver: pixel source and MAC back-pressure.
    initial forever begin
        @(posedge clk); #1;
        pix_valid = vmode_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (stall_left > 0 && win_valid) begin
            win_ready = 1'b0;
            stall_left--;
        end else begin
            win_ready = rmode_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: reference pixel walk plus window scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            pend = 0; pv = 0; phs = 0;
        end else begin
            if (pv && !phs) begin
                chk("hold_valid", win_valid, 1);
                chk("hold_row", out_row, prow);
                chk("hold_col", out_col, pcol);
            end
            if (pend) begin
                chk("raise_valid", win_valid, 1);
                chk("raise_row", out_row, pend_r);
                chk("raise_col", out_col, pend_c);
                pend = 0;
            end
            if (win_valid && !win_ready) begin
                chk("stall_pix_ready", pix_ready, 0);
                chk("stall_ff_wen", ff_wen, 0);
            end
            if (ff_wen || ff_ren) begin
                tr = pix_k / cur_rl;
                tc = pix_k % cur_rl;
                chk("ren_needs_wen", ff_wen, 1);
                chk("ren_row_ge2", ff_ren, int'(tr >= 2));
                if (tr >= 2 && tc >= 2 && (tr - 2) % cur_s == 0 && (tc - 2) % cur_s == 0) begin
                    pend = 1; pend_r = (tr - 2) / cur_s; pend_c = (tc - 2) / cur_s;
                end
            end
            if (ff_wen) begin pix_k++; n_wen++; end
            if (ff_ren) n_ren++;
            if (ff_rst) n_rst++;
            if (win_valid && win_ready) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL extra_window row=%0d col=%0d expected=none", out_row, out_col);
                end else begin
                    w = sb.pop_front();
                    chk("win_row", out_row, w.r);
                    chk("win_col", out_col, w.c);
                end
                last_hs_cyc = cyc;
            end
            if (done && gap_chk) chk("done_after_last_window", cyc - last_hs_cyc, 1);
            pv = win_valid; phs = win_valid && win_ready; prow = out_row; pcol = out_col;
        end
    end

    task automatic pulse_start(input int rl, input int cl, input int s);
        @(posedge clk); #1;
        start = 1'b1; row_len = 5'(rl); col_len = 5'(cl); stride = 3'(s);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic load_frame(input int rl, input int cl, input int s);
        for (int oy = 0; oy < (cl - 3) / s + 1; oy++)
            for (int ox = 0; ox < (rl - 3) / s + 1; ox++)
                sb.push_back('{r: oy, c: ox});
        cur_rl = rl; cur_s = s; pix_k = 0; n_wen = 0; n_ren = 0; n_rst = 0;
    endtask

    task automatic run_frame(input int rl, input int cl, input int s, input bit vr,
                             input bit rr, input int stall, input bit poke);
        bit got = 0;
        load_frame(rl, cl, s);
        gap_chk = ((rl - 3) % s == 0) && ((cl - 3) % s == 0);
        vmode_rand = vr; rmode_rand = rr; stall_left = stall;
        pulse_start(rl, cl, s);
        if (poke) begin
            repeat (6) @(posedge clk);
            pulse_start(3, 3, 1);   // must be ignored while busy
        end
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk); #1;
            if (done) begin got = 1; break; end
        end
        chk("done_seen", got, 1);
        chk("wen_count", n_wen, rl * cl);
        chk("ren_count", n_ren, (cl - 2) * rl);
        chk("rst_count", n_rst, 1);
        chk("windows_left", sb.size(), 0);
        @(negedge clk); #1;
        chk("done_pulse_width", done, 0);
        chk("busy_after_done", busy, 0);
        sb.delete();
    endtask

    task automatic bad_cfg(input int rl, input int cl, input int s);
        @(posedge clk); #1;
        start = 1'b1; row_len = 5'(rl); col_len = 5'(cl); stride = 3'(s);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_err_busy", busy, 0);
        chk("cfg_err_no_strobe", {ff_rst, ff_wen, ff_ren}, 0);
        @(negedge clk);
        chk("cfg_err_one_cycle", cfg_err, 0);
        chk("cfg_err_still_idle", busy, 0);
    endtask

    initial begin
        #12;
        chk("reset_outputs", {pix_ready, ff_rst, ff_wen, ff_ren, win_valid, busy, done,
                              cfg_err, out_row, out_col}, 0);
        @(negedge clk); rst = 1'b1;

        run_frame(5, 5, 1, 0, 0, 0, 0);   // T1
        run_frame(6, 6, 2, 0, 0, 0, 0);   // T2
        run_frame(5, 5, 1, 0, 0, 4, 0);   // T3
        bad_cfg(2, 5, 1);                  // T4
        bad_cfg(5, 5, 3);
        bad_cfg(5, 2, 2);
        run_frame(5, 5, 1, 0, 0, 0, 1);   // start while busy

        // T5: asynchronous reset mid-frame
        load_frame(5, 5, 1);
        gap_chk = 0; vmode_rand = 0; rmode_rand = 0; stall_left = 0;
        pulse_start(5, 5, 1);
        for (int i = 0; i < 200 && pix_k < 12; i++) begin @(negedge clk); #1; end
        chk("mid_frame_pixels", int'(pix_k >= 12), 1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", {pix_ready, ff_rst, ff_wen, ff_ren, win_valid, busy, done,
                                    cfg_err, out_row, out_col}, 0);
        sb.delete();
        @(negedge clk); #1;
        rst = 1'b1;
        run_frame(5, 5, 1, 0, 0, 0, 0);

        run_frame(5, 5, 1, 1, 0, 0, 0);   // T6
        for (int k = 0; k < 6; k++)
            run_frame($urandom_range(3, 12), $urandom_range(3, 12), $urandom_range(1, 2),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
